// File: rtl/if_stage_pkg.sv
// Shared fetch-stage types and constants.
// fetch_entry_t is also the IF/ID register payload.
package if_stage_pkg;

  localparam int ADDR_W   = 8;
  localparam int INSTR_W  = 16;
  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] HALT_OP = 4'hF;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [OPCODE_W-1:0] get_opcode(
    input logic [INSTR_W-1:0] instr
  );
    return instr[INSTR_W-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetch entries with flush.
// Head is muxed from registers and holds its last value when empty.
module fetch_queue
  import if_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  data_i,
  input  logic          pop_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t  head_o
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  last_q;
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      last_q  <= head_o;
    end else begin
      if (push_i) wr_q <= wr_q + PW'(1);
      if (pop_i)  rd_q <= rd_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
      last_q  <= head_o;
    end
  end

  assign count_o = count_q;
  assign head_o  = (count_q != '0) ? mem_q[rd_q] : last_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, imem issue, in-flight tracking,
// halt handling and a fetch queue feeding IF/ID.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                QDEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               valid_out,
  output logic [INSTR_W-1:0] instruc_out,
  output logic [ADDR_W-1:0]  addr_out,
  output logic               halted
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fl_addr_q, fl_addr_d;
  logic              inflight_q, inflight_d;
  logic              halted_q, halted_d;
  logic              push, pop;
  logic [CW-1:0]     count;
  logic [CW:0]       occ;
  fetch_entry_t      head, push_data;

  assign pop = valid_out && !stall;
  // Slots committed after this cycle: queued + returning - leaving
  assign occ = (CW+1)'(count) + (CW+1)'(inflight_q)
             - (CW+1)'(pop);

  assign imem_req = !reset && !halted_q && !branch_taken
                 && (occ < (CW+1)'(QDEPTH));
  assign imem_addr = pc_q;

  assign push      = inflight_q && !halted_q && !branch_taken;
  assign push_data = '{addr: fl_addr_q, instr: imem_data};

  always_comb begin
    pc_d       = pc_q;
    fl_addr_d  = fl_addr_q;
    inflight_d = imem_req;
    halted_d   = halted_q;
    if (branch_taken) begin
      pc_d       = branch_target;
      inflight_d = 1'b0;
      halted_d   = 1'b0;
    end else begin
      if (imem_req) begin
        pc_d      = pc_q + ADDR_W'(1);
        fl_addr_d = pc_q;
      end
      if (push && get_opcode(imem_data) == HALT_OP)
        halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      fl_addr_q  <= '0;
      inflight_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      fl_addr_q  <= fl_addr_d;
      inflight_q <= inflight_d;
      halted_q   <= halted_d;
    end
  end

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_fq (
    .clk    (clk),
    .rst_i  (reset),
    .flush_i(branch_taken),
    .push_i (push),
    .data_i (push_data),
    .pop_i  (pop),
    .count_o(count),
    .head_o (head)
  );

  assign valid_out   = (count != '0);
  assign instruc_out = head.instr;
  assign addr_out    = head.addr;
  assign halted      = halted_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: latency, stall, redirect,
// PC wrap, halt and mid-run reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = '0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data = '0;
  logic        valid_out;
  logic [15:0] instruc_out;
  logic [7:0]  addr_out;
  logic        halted;

  int checks   = 0;
  int failures = 0;
  bit halt_en  = 1'b0;

  if_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .valid_out    (valid_out),
    .instruc_out  (instruc_out),
    .addr_out     (addr_out),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [7:0] a);
    if (halt_en && a == 8'h03) return 16'hF000;
    return 16'h1000 + {8'h00, a};
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_data <= mem_f(imem_addr);
  end

  always @(posedge clk) begin
    if (!reset && !branch_taken) begin
      assert (!(dut.push && !dut.pop && int'(dut.count) >= 2))
        else $error("FAIL queue overflow");
      assert (!(dut.pop && int'(dut.count) == 0))
        else $error("FAIL queue underflow");
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rs, input logic st,
                     input logic br, input logic [7:0] tg);
    @(posedge clk);
    #1;
    reset         = rs;
    stall         = st;
    branch_taken  = br;
    branch_target = tg;
    #1;
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
  endtask

  logic [7:0] wrap_a [4];

  initial begin
    wrap_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    // Reset release and steady stream
    do_reset();
    chk("rst_valid", valid_out, 0);
    chk("rst_instr", instruc_out, 0);
    chk("rst_addr", addr_out, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_halted", halted, 0);
    cyc(0, 0, 0, 8'h00);
    chk("c0_req", imem_req, 1);
    chk("c0_iaddr", imem_addr, 8'h00);
    cyc(0, 0, 0, 8'h00);
    chk("c1_valid", valid_out, 0);
    cyc(0, 0, 0, 8'h00);
    chk("c2_valid", valid_out, 1);
    chk("c2_addr", addr_out, 8'h00);
    chk("c2_instr", instruc_out, 16'h1000);
    cyc(0, 0, 0, 8'h00);
    chk("c3_addr", addr_out, 8'h01);
    cyc(0, 0, 0, 8'h00);
    chk("c4_addr", addr_out, 8'h02);

    for (int c = 5; c <= 10; c++) begin
      cyc(0, 1, 0, 8'h00);
      chk("stall_valid", valid_out, 1);
      chk("stall_addr", addr_out, 8'h03);
      chk("stall_instr", instruc_out, 16'h1003);
      chk("stall_req", imem_req, 0);
    end
    cyc(0, 0, 0, 8'h00);
    chk("rel_addr0", addr_out, 8'h03);
    chk("rel_req", imem_req, 1);
    chk("rel_iaddr", imem_addr, 8'h05);
    cyc(0, 0, 0, 8'h00);
    chk("rel_addr1", addr_out, 8'h04);
    cyc(0, 0, 0, 8'h00);
    chk("rel_addr2", addr_out, 8'h05);
    chk("rel_instr2", instruc_out, 16'h1005);

    // Redirect during stall
    do_reset();
    for (int c = 0; c <= 5; c++) cyc(0, 0, 0, 8'h00);
    cyc(0, 1, 1, 8'h40);
    chk("br_req", imem_req, 0);
    cyc(0, 0, 0, 8'h00);
    chk("br1_valid", valid_out, 0);
    chk("br1_req", imem_req, 1);
    chk("br1_iaddr", imem_addr, 8'h40);
    cyc(0, 0, 0, 8'h00);
    chk("br2_valid", valid_out, 0);
    cyc(0, 0, 0, 8'h00);
    chk("br3_valid", valid_out, 1);
    chk("br3_addr", addr_out, 8'h40);
    chk("br3_instr", instruc_out, 16'h1040);
    cyc(0, 0, 0, 8'h00);
    chk("br4_addr", addr_out, 8'h41);

    // PC wrap
    cyc(0, 0, 1, 8'hFE);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    chk("wr_gap", valid_out, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 8'h00);
      chk("wrap_valid", valid_out, 1);
      chk("wrap_addr", addr_out, wrap_a[i]);
      chk("wrap_instr", instruc_out, 16'h1000 + {8'h00, wrap_a[i]});
    end

    // Halt at address 03
    halt_en = 1'b1;
    do_reset();
    for (int c = 0; c <= 3; c++) cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    chk("h4_addr", addr_out, 8'h02);
    chk("h4_halted", halted, 0);
    cyc(0, 0, 0, 8'h00);
    chk("h5_addr", addr_out, 8'h03);
    chk("h5_instr", instruc_out, 16'hF000);
    chk("h5_halted", halted, 1);
    chk("h5_req", imem_req, 0);
    for (int c = 6; c <= 9; c++) begin
      cyc(0, 0, 0, 8'h00);
      chk("hd_valid", valid_out, 0);
      chk("hd_req", imem_req, 0);
      chk("hd_addr", addr_out, 8'h03);
      chk("hd_halted", halted, 1);
    end
    cyc(0, 0, 1, 8'h10);
    chk("hb_req", imem_req, 0);
    cyc(0, 0, 0, 8'h00);
    chk("hb1_halted", halted, 0);
    chk("hb1_req", imem_req, 1);
    chk("hb1_iaddr", imem_addr, 8'h10);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    chk("hb3_valid", valid_out, 1);
    chk("hb3_addr", addr_out, 8'h10);
    chk("hb3_instr", instruc_out, 16'h1010);
    halt_en = 1'b0;

    // Reset with queue full and a response returning
    do_reset();
    for (int c = 0; c <= 4; c++) cyc(0, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    chk("mr_full", valid_out, 1);
    cyc(1, 0, 0, 8'h00);
    chk("mr_req", imem_req, 0);
    cyc(0, 0, 0, 8'h00);
    chk("mr1_valid", valid_out, 0);
    chk("mr1_halted", halted, 0);
    chk("mr1_req", imem_req, 1);
    chk("mr1_iaddr", imem_addr, 8'h00);
    cyc(0, 0, 0, 8'h00);
    chk("mr2_valid", valid_out, 0);
    cyc(0, 0, 0, 8'h00);
    chk("mr3_valid", valid_out, 1);
    chk("mr3_addr", addr_out, 8'h00);
    chk("mr3_instr", instruc_out, 16'h1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
